// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state, next-PC select and opcode definitions for the fetch stage.
package cpu_pkg;
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HALT_LOOP  = 2'd1,
    HALT_FAULT = 2'd2
  } state_t;
  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } sel_t;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: branch/jump target arithmetic and prioritised next-PC select.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic        beq,
  input  logic        bne,
  input  logic        z,
  input  logic        j,
  input  logic        jal,
  input  logic        jr,
  input  logic [25:0] target26,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output sel_t        sel
);
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        taken;
  assign taken     = (beq & z) | (bne & ~z);
  assign br_target = pc_plus4 + {{14{target26[15]}}, target26[15:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], target26, 2'b00};
  always_comb begin
    sel     = jr ? SEL_JR : (j | jal) ? SEL_J : taken ? SEL_BR : SEL_SEQ;
    next_pc = sel == SEL_JR ? rs_data :
              sel == SEL_J  ? j_target :
              sel == SEL_BR ? br_target : pc_plus4;
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, run/halt state machine, fault detection and retired-instruction counter.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 32,
  parameter int          CNT_W     = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Beq,
  input  logic             Bne,
  input  logic             Z,
  input  logic             J,
  input  logic             Jal,
  input  logic             Jr,
  input  logic [31:0]      Inst,
  input  logic [31:0]      RsData,
  output logic [31:0]      Addr,
  output logic [31:0]      PcPlus4,
  output logic [31:0]      LinkAddr,
  output logic             Halted,
  output logic             Fault,
  output logic [CNT_W-1:0] InstCount
);
  localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + 33'(4 * ROM_WORDS);
  state_t           state, state_d;
  logic [31:0]      addr_d;
  logic [CNT_W-1:0] cnt_d;
  logic [31:0]      next_pc;
  sel_t             sel;
  logic             bad, self_loop;
  logic             unused_opcode;
  assign unused_opcode = ^Inst[31:26];
  assign PcPlus4  = Addr + 32'd4;
  assign LinkAddr = PcPlus4;
  assign Halted   = state != RUN;
  assign Fault    = state == HALT_FAULT;
  next_pc_calc u_next_pc (
    .pc_plus4 (PcPlus4),
    .beq      (Beq),
    .bne      (Bne),
    .z        (Z),
    .j        (J),
    .jal      (Jal),
    .jr       (Jr),
    .target26 (Inst[25:0]),
    .rs_data  (RsData),
    .next_pc  (next_pc),
    .sel      (sel)
  );
  // Range is checked in 33 bits so a ROM ending at 2^32 cannot wrap the limit.
  assign bad       = (next_pc[1:0] != 2'b00) || (next_pc < RESET_PC) || ({1'b0, next_pc} >= PC_LIMIT);
  assign self_loop = (sel != SEL_SEQ) && (next_pc == Addr);
  always_comb begin
    state_d = state;
    addr_d  = Addr;
    cnt_d   = InstCount;
    if (state == RUN && !Stall) begin
      state_d = bad ? HALT_FAULT : self_loop ? HALT_LOOP : RUN;
      addr_d  = (bad || self_loop) ? Addr : next_pc;
      cnt_d   = bad ? InstCount : InstCount + CNT_W'(1);
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= RUN;
      Addr      <= RESET_PC;
      InstCount <= '0;
    end else begin
      state     <= state_d;
      Addr      <= addr_d;
      InstCount <= cnt_d;
    end
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and next-address stage of the single-cycle MIPS CPU; sits directly upstream of the instruction memory.
- Holds the PC register and drives the word address into the 32-entry instruction ROM, which decodes Addr[6:2].
- Each cycle it selects the next PC from control and datapath inputs: sequential, beq/bne, j/jal, or jr.
- Tracks run/halt state, detects faults, counts retired instructions and supplies the jal link address.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ROM_WORDS, 32, number of instruction words; the legal PC range is [RESET_PC, RESET_PC + 4*ROM_WORDS).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- Clk in 1: rising-edge clock.
- Reset in 1: synchronous, active-high reset.
- Stall in 1: hold PC this cycle; nothing retires.
- Beq in 1: current instruction is beq.
- Bne in 1: current instruction is bne.
- Z in 1: ALU zero flag for the current instruction.
- J in 1: current instruction is j.
- Jal in 1: current instruction is jal.
- Jr in 1: current instruction is jr.
- Inst in 32: current instruction word from instruction memory; supplies imm16 [15:0] and target26 [25:0].
- RsData in 32: register-file rs read value, used as the jr target.
- Addr out 32: current PC, drives the instruction-memory address.
- PcPlus4 out 32: Addr + 4.
- LinkAddr out 32: value written to $31 on jal; equals PcPlus4.
- Halted out 1: high in any halt state.
- Fault out 1: high in HALT_FAULT only.
- InstCount out CNT_W: number of retired instructions.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high, sampled on the Clk rising edge.
- Reset values: Addr=RESET_PC, state=RUN, Halted=0, Fault=0, InstCount=0. Reset overrides all other inputs, including in mid-stall or halt.
- Combinational outputs: PcPlus4 and LinkAddr are Addr+4, 32-bit, wrap modulo 2^32.
- Next-PC select, in priority order: Jr > (J|Jal) > branch taken > sequential.
  - Branch taken = (Beq & Z) | (Bne & ~Z).
  - Branch target = PcPlus4 + (sign-extended imm16 << 2), 32-bit wrap.
  - Jump target = {PcPlus4[31:28], target26, 2'b00}.
  - Jr target = RsData.
- States:
  - RUN:
    - Stall=1: Addr holds, count holds.
    - Otherwise: Addr <= next PC, InstCount += 1, wrapping at 2^CNT_W.
  - HALT_LOOP:
    - Entered when a non-stalled j/jal/taken-branch/jr target equals the current Addr.
    - The self-loop instruction retires (count +1); Addr is unchanged.
    - Terminal until Reset.
  - HALT_FAULT:
    - Entered when a non-stalled cycle's next PC has bits [1:0] != 0, or falls outside the legal range.
    - Addr keeps the PC of the faulting instruction; that instruction does not retire (count unchanged).
    - Fault=1. Terminal until Reset.
- Check order: fault is checked before self-loop. A misaligned self-target is a fault.
- In either halt state, Addr, InstCount and state ignore all inputs except Reset.
- Latency: the PC update is visible on Addr one cycle after the retiring edge. Halted/Fault are registered, asserting in the same cycle the state changes.
- Stall combined with a control input: no effect. Stall is sampled only in RUN.
- Sequential overflow: PcPlus4 past the legal range is a fault (falling off the end of the ROM).

Decomposition:
- Shared package cpu_pkg:
  - State encoding: RUN=2'd0, HALT_LOOP=2'd1, HALT_FAULT=2'd2.
  - Next-PC select codes: SEL_SEQ, SEL_BR, SEL_J, SEL_JR.
  - Opcode constants used by the control unit (BEQ 6'h04, BNE 6'h05, J 6'h02, JAL 6'h03).
- Natural sub-module: next_pc_calc. Purely combinational; holds the target arithmetic and priority select. The top level keeps the PC register, state machine, counter and range/alignment checks.

Test Plan:
- Reset, then 5 unstalled cycles with no control inputs -> Addr sequence 0x00, 0x04, 0x08, 0x0C, 0x10, 0x14; InstCount=5.
- At Addr=0x3C: Jal=1, Inst=32'h0c000013 -> LinkAddr=0x40, next Addr=0x4C. Then Jr=1, RsData=0x40 -> Addr=0x40.
- At Addr=0x50: Beq=1, Z=1, imm=4 -> Addr=0x64.
- At Addr=0x50: Bne=1, Z=1 -> Addr=0x54.
- At Addr=0x64: Bne=1, Z=0, imm=5 -> Addr=0x7C.
- Stall=1 for 3 cycles with J=1 at Addr=0x40 -> Addr and InstCount frozen. Release -> Addr=0x50 (Inst=32'h08000014).
- At Addr=0x10: Jr=1, RsData=0x22 -> HALT_FAULT, Fault=1, Addr stays 0x10, count unchanged.
- Separately: J to own address 0x7C (Inst=32'h0800001F) -> HALT_LOOP, Halted=1, Fault=0, count +1.
- Assert Reset while in HALT_LOOP -> next cycle Addr=0, Halted=0, InstCount=0.
- Assert Reset during a stall -> same reset values as above.
